// File: rtl/fifo_pkg.sv
// Shared constants for the fifo block and its read-side stream adapter.
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int SKID_DEPTH     = 3;
    localparam int RD_LATENCY     = 1;

    typedef logic [1:0] skid_ptr_t;

    // Advance a skid-buffer pointer, wrapping modulo SKID_DEPTH.
    function automatic skid_ptr_t skid_ptr_inc(input skid_ptr_t ptr);
        return (ptr == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Three-entry circular skid buffer that absorbs FIFO read latency and sink back-pressure.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       occ_o,
    output logic [WIDTH-1:0] head_data_o
);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    skid_ptr_t        head_q;
    skid_ptr_t        tail_q;
    logic [1:0]       occ_q;

    // Storage, pointers and occupancy; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_data_i;
                tail_q        <= skid_ptr_inc(tail_q);
            end
            if (pop_i) begin
                head_q <= skid_ptr_inc(head_q);
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ_o       = occ_q;
    assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/fifo_stream_adapter.sv
// Drains the fifo read port into a valid/ready stream with packet framing and a transfer count.
module fifo_stream_adapter
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    output logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    localparam int                BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic                 inflight_q;
    logic                 inflight_d;
    logic [BEAT_W-1:0]    beat_q;
    logic [BEAT_W-1:0]    beat_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [1:0]           occ;
    logic [2:0]           fill;
    logic                 pop;

    fifo_rd_skid #(
        .WIDTH(FIFO_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rstN       (rstN),
        .push_i     (inflight_q),
        .push_data_i(fifo_data),
        .pop_i      (pop),
        .occ_o      (occ),
        .head_data_o(m_data)
    );

    // Words buffered plus the one possibly in flight must never exceed the skid depth,
    // so a read is issued only while there is guaranteed room for its data.
    assign fill    = {1'b0, occ} + {2'b00, inflight_q};
    assign rd_en   = !fifo_empty && rstN && (fill < 3'(SKID_DEPTH));
    assign m_valid = rstN && (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_last  = m_valid && (beat_q == BEAT_LAST);
    assign xfer_cnt = cnt_q;

    // Next-state values for the in-flight flag, packet beat and transfer counter.
    always_comb begin
        inflight_d = rd_en;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        if (pop) begin
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Register read tracking and framing state; reset drops any word still in flight.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: behavioural fifo, word-order scoreboard and framing/count model.
module tb_fifo_stream_adapter;

    localparam int W   = 8;
    localparam int PKT = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rstN;
    logic          rd_en;
    logic [W-1:0]  fifo_data = '0;
    logic          fifo_empty;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic [CW-1:0] xfer_cnt;

    always #5 clk = ~clk;

    fifo_stream_adapter #(
        .FIFO_WIDTH(W),
        .PKT_LEN   (PKT),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .rd_en     (rd_en),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .xfer_cnt  (xfer_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Upstream fifo: data appears one cycle after a granted read.
    logic [W-1:0] fifo_mem [0:1023];
    int           wr_cnt = 0;
    int           rd_ptr = 0;
    int           rd_cnt = 0;

    assign fifo_empty = (rd_ptr == wr_cnt);

    always @(posedge clk) begin
        if (rd_en && !fifo_empty) begin
            fifo_data <= fifo_mem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
            rd_cnt    <= rd_cnt + 1;
        end
    end

    logic [W-1:0] exp_q [$];

    task automatic push_word(input logic [W-1:0] d);
        fifo_mem[wr_cnt[9:0]] = d;
        wr_cnt++;
        exp_q.push_back(d);
    endtask

    // Reference model: words leave in fifo order, every PKT-th accepted word is last,
    // the counter equals accepted words mod 2^CW, and reads minus accepts stays within 3.
    int acc_cnt     = 0;
    int model_beat  = 0;
    int outstanding = 0;

    always @(negedge clk) begin
        if (!rstN) begin
            acc_cnt     = 0;
            model_beat  = 0;
            outstanding = 0;
        end else begin
            check("xfer_cnt", 32'(xfer_cnt), 32'(acc_cnt % (1 << CW)));
            check("rd_en_while_empty", 32'(rd_en && fifo_empty), 32'(0));
            if (m_valid && m_ready) begin
                check("word_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    check("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
                end
                check("m_last", 32'(m_last), 32'(model_beat == PKT - 1));
                acc_cnt++;
                model_beat = (model_beat + 1) % PKT;
            end
            outstanding = outstanding + int'(rd_en && !fifo_empty) - int'(m_valid && m_ready);
            check("skid_overflow", 32'(outstanding <= 3), 32'(1));
        end
    end

    task automatic reset_pulse();
        @(posedge clk);
        #1 rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
    endtask

    task automatic drain(output int n_last, output logic [W-1:0] last_word);
        n_last    = 0;
        last_word = '0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (m_valid && m_ready && m_last) begin
                n_last++;
                last_word = m_data;
            end
            if (exp_q.size() == 0 && !m_valid && fifo_empty) break;
        end
        check("drain_done", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int           nl;
        logic [W-1:0] lw;
        int           base;
        int           sent;
        int           cyc;
        int           acc0;

        // Reset held with a word waiting in the fifo.
        rstN    = 1'b0;
        m_ready = 1'b1;
        push_word(8'h11);
        repeat (3) begin
            @(negedge clk);
            check("rst_rd_en", 32'(rd_en), 32'(0));
            check("rst_m_valid", 32'(m_valid), 32'(0));
            check("rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        end
        @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        check("first_rd_en", 32'(rd_en), 32'(1));
        @(negedge clk);
        check("lat_no_valid", 32'(m_valid), 32'(0));
        @(negedge clk);
        check("lat_valid", 32'(m_valid), 32'(1));
        check("lat_data", 32'(m_data), 32'(8'h11));
        drain(nl, lw);

        // Back-to-back streaming of 0x01..0x08.
        reset_pulse();
        @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        @(negedge clk);
        check("s_rd_en", 32'(rd_en), 32'(1));
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("s_valid", 32'(m_valid), 32'(1));
        end
        @(negedge clk);
        check("s_xfer_cnt", 32'(xfer_cnt), 32'(8));
        check("s_idle", 32'(m_valid), 32'(0));

        // Back-pressure: exactly three reads, head word held.
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        base    = rd_cnt;
        for (int i = 0; i < 6; i++) push_word(8'(8'hA0 + i));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_valid) check("bp_hold", 32'(m_data), 32'(8'hA0));
        end
        check("bp_reads", 32'(rd_cnt - base), 32'(3));
        check("bp_valid", 32'(m_valid), 32'(1));
        check("bp_rd_en", 32'(rd_en), 32'(0));
        @(posedge clk);
        #1 m_ready = 1'b1;
        drain(nl, lw);

        // Random ready and random fifo fill over 200 words.
        acc0 = acc_cnt;
        sent = 0;
        cyc  = 0;
        while (sent < 200 && cyc < 5000) begin
            @(posedge clk);
            #1;
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                push_word(8'($urandom));
                sent++;
            end
            cyc++;
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        drain(nl, lw);
        check("rand_sent", 32'(sent), 32'(200));
        check("rand_accepted", 32'(acc_cnt - acc0), 32'(200));

        // Reset in the middle of a packet restarts framing.
        reset_pulse();
        @(posedge clk);
        #1;
        push_word(8'hB0);
        push_word(8'hB1);
        drain(nl, lw);
        check("mid_cnt", 32'(xfer_cnt), 32'(2));
        reset_pulse();
        @(negedge clk);
        check("post_rst_cnt", 32'(xfer_cnt), 32'(0));
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i));
        drain(nl, lw);
        check("rst_last_count", 32'(nl), 32'(1));
        check("rst_last_word", 32'(lw), 32'(8'hC3));
        check("rst_xfer_cnt4", 32'(xfer_cnt), 32'(4));

        // Counter wrap with a 4-bit counter.
        reset_pulse();
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) push_word(8'(8'hD0 + i));
        drain(nl, lw);
        check("wrap_cnt", 32'(xfer_cnt), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
